// File: rtl/router_pkt_tx_if.sv
// Upstream client and router-side signals of the router packet transmitter.
// Define PKT_TX_PARITY_CORRUPT_EN to add the corrupt_parity request line.
interface router_pkt_tx_if;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] payload_len;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       tx_busy;
    logic       tx_done;
    logic       start_err;
`ifdef PKT_TX_PARITY_CORRUPT_EN
    logic       corrupt_parity;
`endif

    modport master (
`ifdef PKT_TX_PARITY_CORRUPT_EN
        output corrupt_parity,
`endif
        output start, dest_addr, payload_len,
        output pl_data, pl_valid, busy,
        input  pl_ready, pkt_data, pkt_valid,
        input  tx_busy, tx_done, start_err
    );

    modport slave (
`ifdef PKT_TX_PARITY_CORRUPT_EN
        input  corrupt_parity,
`endif
        input  start, dest_addr, payload_len,
        input  pl_data, pl_valid, busy,
        output pl_ready, pkt_data, pkt_valid,
        output tx_busy, tx_done, start_err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for the router input: buffers a payload, then sends header,
// payload and XOR parity. PKT_TX_PARITY_CORRUPT_EN enables parity inversion.
module router_pkt_tx #(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input logic clock,
    input logic resetn,
    router_pkt_tx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP
    } state_t;

    localparam logic [3:0] GAP_N = 4'(GAP_CYCLES);

    state_t     state;
    logic [1:0] addr_q;
    logic [5:0] len_q;
    logic [5:0] wptr;
    logic [5:0] rptr;
    logic [7:0] parity;
    logic [3:0] gap_cnt;
    logic [7:0] buf_q [MAX_LEN];

    logic [7:0] pkt_data_q;
    logic       pkt_valid_q;
    logic       pl_ready_q;
    logic       tx_busy_q;
    logic       tx_done_q;
    logic       start_err_q;

    logic       start_bad;
    logic       load_fire;
    logic [7:0] hdr_in;
    logic [7:0] hdr_q;
    logic [7:0] par_mask;

    assign start_bad = (bus.dest_addr == 2'd3)
                    || (bus.payload_len == 6'd0)
                    || (bus.payload_len > 6'(MAX_LEN));
    assign load_fire = (state == LOAD) && bus.pl_valid && pl_ready_q;
    assign hdr_in    = {bus.payload_len, bus.dest_addr};
    assign hdr_q     = {len_q, addr_q};

`ifdef PKT_TX_PARITY_CORRUPT_EN
    logic corrupt_q;
    assign par_mask = {8{corrupt_q}};
`else
    assign par_mask = 8'h00;
`endif

    assign bus.pkt_data  = pkt_data_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.pl_ready  = pl_ready_q;
    assign bus.tx_busy   = tx_busy_q;
    assign bus.tx_done   = tx_done_q;
    assign bus.start_err = start_err_q;

    // Payload storage carries no reset; pointers define what is valid.
    always_ff @(posedge clock) begin
        if (load_fire)
            buf_q[wptr] <= bus.pl_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            addr_q      <= 2'd0;
            len_q       <= 6'd0;
            wptr        <= 6'd0;
            rptr        <= 6'd0;
            parity      <= 8'h00;
            gap_cnt     <= 4'd0;
            pkt_data_q  <= 8'h00;
            pkt_valid_q <= 1'b0;
            pl_ready_q  <= 1'b0;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            start_err_q <= 1'b0;
`ifdef PKT_TX_PARITY_CORRUPT_EN
            corrupt_q   <= 1'b0;
`endif
        end else begin
            tx_done_q   <= 1'b0;
            start_err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (start_bad) begin
                            start_err_q <= 1'b1;
                        end else begin
                            addr_q     <= bus.dest_addr;
                            len_q      <= bus.payload_len;
                            parity     <= hdr_in;
                            wptr       <= 6'd0;
                            rptr       <= 6'd0;
                            pl_ready_q <= 1'b1;
                            tx_busy_q  <= 1'b1;
`ifdef PKT_TX_PARITY_CORRUPT_EN
                            corrupt_q  <= bus.corrupt_parity;
`endif
                            state      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        parity <= parity ^ bus.pl_data;
                        wptr   <= wptr + 6'd1;
                        if (wptr == len_q - 6'd1) begin
                            pl_ready_q  <= 1'b0;
                            pkt_data_q  <= hdr_q;
                            pkt_valid_q <= 1'b1;
                            state       <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (!bus.busy) begin
                        pkt_data_q <= buf_q[0];
                        rptr       <= 6'd1;
                        state      <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!bus.busy) begin
                        if (rptr == len_q) begin
                            pkt_data_q  <= parity ^ par_mask;
                            pkt_valid_q <= 1'b0;
                            state       <= PARITY;
                        end else begin
                            pkt_data_q <= buf_q[rptr];
                            rptr       <= rptr + 6'd1;
                        end
                    end
                end
                PARITY: begin
                    if (!bus.busy) begin
                        pkt_data_q <= 8'h00;
                        gap_cnt    <= 4'd1;
                        tx_done_q  <= (GAP_N == 4'd1);
                        state      <= GAP;
                    end
                end
                GAP: begin
                    // tx_done is raised so it lands in the final gap cycle
                    if (gap_cnt == GAP_N) begin
                        tx_busy_q <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        gap_cnt   <= gap_cnt + 4'd1;
                        tx_done_q <= (gap_cnt + 4'd1 == GAP_N);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source for the 1x3 router input port. It accepts a destination address, a payload length and payload bytes from an upstream client, and buffers the payload internally. It then drives the router input protocol: a header byte, the payload bytes, and a parity byte. It honours the router's busy back-pressure and generates the even-XOR parity that the router's parity checker expects.

Parameters:
MAX_LEN, 63, maximum payload length in bytes; also the depth of the payload buffer; legal range 1..63
GAP_CYCLES, 2, minimum idle cycles with pkt_valid=0 after the parity byte before the next header; range 1..15

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a packet; sampled only in IDLE
dest_addr  input  2  destination port 0..2; value 3 is illegal
payload_len  input  6  payload byte count, 1..MAX_LEN
pl_data  input  8  upstream payload byte
pl_valid  input  1  pl_data valid
pl_ready  output  1  transmitter accepts pl_data this cycle
busy  input  1  router back-pressure; hold the current byte while high
pkt_data  output  8  byte to router data_in
pkt_valid  output  1  high for header and payload, low for parity and idle
tx_busy  output  1  high in every state except IDLE
tx_done  output  1  one-cycle pulse at the end of GAP
start_err  output  1  one-cycle pulse when a start request is rejected

Behaviour:
- Reset (async, resetn=0): state=IDLE; pkt_data=0, pkt_valid=0, pl_ready=0, tx_busy=0, tx_done=0, start_err=0; parity, counters and buffer pointers cleared. Reset asserted mid-packet aborts the packet immediately; no parity byte is sent.
- All outputs are registered.
- Header byte = {payload_len[5:0], dest_addr[1:0]}.
- Parity = header XOR all payload bytes.
- IDLE:
  - start with dest_addr==3, payload_len==0 or payload_len>MAX_LEN: start_err pulses the next cycle; state stays IDLE.
  - Legal start: latch addr and len; parity <= header; go to LOAD.
  - start outside IDLE is ignored; no start_err.
- LOAD:
  - pl_ready=1.
  - Each cycle with pl_valid&&pl_ready: write buffer[wptr], parity ^= pl_data, wptr++.
  - After the len-th byte: pl_ready drops the next cycle; state goes to HEADER.
  - pl_valid gaps just stall LOAD; there is no timeout.
- Byte acceptance rule (HEADER/PAYLOAD/PARITY): a presented byte is consumed at a rising edge where busy==0. While busy==1, pkt_data and pkt_valid hold unchanged.
- HEADER: pkt_data=header, pkt_valid=1. When consumed, go to PAYLOAD.
- PAYLOAD:
  - pkt_data=buffer[rptr], pkt_valid=1; rptr advances on consume.
  - After the last byte is consumed, go to PARITY. There are no bubbles between bytes when busy stays low.
- PARITY: pkt_data=parity, pkt_valid=0. When consumed, go to GAP.
- GAP:
  - pkt_valid=0, pkt_data=0, busy ignored.
  - Counts GAP_CYCLES cycles; tx_done pulses in the last cycle; then IDLE.
- Latency, busy low throughout, counted from the cycle after LOAD completes:
  - header appears 1 cycle later;
  - total on-wire bytes = len+2 in len+2 consecutive cycles.
- Buffer pointers are 6-bit, reset to 0 at each legal start; there is no wrap within a packet.

Optional Feature:
PKT_TX_PARITY_CORRUPT_EN
- Defined: adds input port corrupt_parity (1 bit), latched at a legal start. When set, the parity byte sent is ~parity. Used to exercise the router error flag.
- Undefined: the port is absent and the correct parity is always sent.

Test Plan:
- addr=1, len=4, payload 11,22,33,44, busy=0 -> pkt_data 0x11(v=1), 11,22,33,44(v=1), 0x55(v=0); then GAP_CYCLES idle cycles; tx_done pulses once.
- Same packet with busy=1 for 3 cycles while 0x22 is presented -> 0x22 with pkt_valid=1 held for 4 cycles total; remaining sequence unchanged; parity 0x55.
- start with dest_addr=3, or len=0 -> start_err pulses once; tx_busy stays 0; pl_ready stays 0; no bytes driven.
- addr=2, len=63, all payload 0xFF, pl_valid toggling every other cycle -> LOAD takes 125 cycles; header 0xFE; 63 bytes of 0xFF; parity 0x01 with v=0.
- resetn low during PAYLOAD byte 2 -> pkt_valid=0 and pkt_data=0 asynchronously; state IDLE; a following legal start sends a clean packet.
- With PKT_TX_PARITY_CORRUPT_EN and corrupt_parity=1 on the first scenario -> parity byte is 0xAA; all other bytes unchanged.
